// File: rtl/seq_encoder_if.sv
// Handshake bundle for seq_encoder: a vector-in channel and an index-out channel.
// The out_last signal exists only when ENC_LAST_EN is defined.
interface seq_encoder_if #(
  parameter int N = 4
);
  localparam int W = $clog2(N);

  logic [N-1:0] in_vec;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
`ifdef ENC_LAST_EN
  logic         out_last;

  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_idx, out_valid, out_last
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_idx, out_valid, out_last
  );
`else
  modport master (
    output in_vec, in_valid, out_ready,
    input  in_ready, out_idx, out_valid
  );

  modport slave (
    input  in_vec, in_valid, out_ready,
    output in_ready, out_idx, out_valid
  );
`endif
endinterface

// File: rtl/seq_encoder.sv
// Sequential multi-hot to binary encoder: emits one index per set bit, lowest first.
// Optional feature macro ENC_LAST_EN adds a registered out_last flag on the final index.
module seq_encoder #(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_encoder_if.slave  bus
);
  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] idx_q, idx_d;
  logic         valid_q, valid_d;
  logic [N-1:0] remaining;
  logic         accept;
  logic         fire;
`ifdef ENC_LAST_EN
  logic         last_q, last_d;
`endif

  function automatic logic [W-1:0] lowestIdx(input logic [N-1:0] vec);
    lowestIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) lowestIdx = W'(i);
    end
  endfunction

`ifdef ENC_LAST_EN
  function automatic logic isSingleBit(input logic [N-1:0] vec);
    isSingleBit = (vec != '0) && ((vec & (vec - N'(1))) == '0);
  endfunction
`endif

  // Bits still owed after the currently presented index is taken.
  assign remaining = pending_q & ~(N'(1) << idx_q);
  assign accept    = (state_q == IDLE) && bus.in_valid && (bus.in_vec != '0);
  assign fire      = valid_q && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
`ifdef ENC_LAST_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
`ifdef ENC_LAST_EN
      last_q    <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT:    if (fire && (remaining == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // An all-zero vector in IDLE is consumed without producing output.
  always_comb begin
    pending_d = pending_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
`ifdef ENC_LAST_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = bus.in_vec;
          idx_d     = lowestIdx(bus.in_vec);
          valid_d   = 1'b1;
`ifdef ENC_LAST_EN
          last_d    = isSingleBit(bus.in_vec);
`endif
        end
      end
      EMIT: begin
        if (fire) begin
          pending_d = remaining;
          if (remaining == '0) begin
            valid_d = 1'b0;
`ifdef ENC_LAST_EN
            last_d  = 1'b0;
`endif
          end else begin
            idx_d   = lowestIdx(remaining);
`ifdef ENC_LAST_EN
            last_d  = isSingleBit(remaining);
`endif
          end
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_idx   = idx_q;
  assign bus.out_valid = valid_q;
`ifdef ENC_LAST_EN
  assign bus.out_last  = last_q;
`endif

endmodule

// File: tb/tb_seq_encoder.sv
// Randomised self-checking bench for seq_encoder at N=4 and N=8 against a queue-based model.
// Checks out_last as well when ENC_LAST_EN is defined.
module tb_seq_encoder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_encoder_if #(.N(4)) bus4 ();
  seq_encoder_if #(.N(8)) bus8 ();

  seq_encoder #(.N(4)) u_enc4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  seq_encoder #(.N(8)) u_enc8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  task automatic drive(input bit use8, input logic iv, input logic [7:0] vec, input logic ordy);
    if (use8) begin
      bus8.in_valid  = iv;
      bus8.in_vec    = vec;
      bus8.out_ready = ordy;
    end else begin
      bus4.in_valid  = iv;
      bus4.in_vec    = vec[3:0];
      bus4.out_ready = ordy;
    end
  endtask

  task automatic sample(input bit use8, output logic [2:0] idx, output logic v,
                        output logic rdy, output logic last);
    idx  = use8 ? bus8.out_idx : {1'b0, bus4.out_idx};
    v    = use8 ? bus8.out_valid : bus4.out_valid;
    rdy  = use8 ? bus8.in_ready : bus4.in_ready;
    last = 1'b0;
`ifdef ENC_LAST_EN
    last = use8 ? bus8.out_last : bus4.out_last;
`endif
  endtask

  task automatic test_reset();
    logic [2:0] idx;
    logic v, r, l;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      sample(d[0], idx, v, r, l);
      checks++;
      if (v !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid dut%0d: got %b expected 0", d, v); end
      checks++;
      if (r !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready dut%0d: got %b expected 1", d, r); end
      checks++;
      if (idx !== 3'd0) begin failures++; $display("[TB] FAIL reset_idx dut%0d: got %0d expected 0", d, idx); end
`ifdef ENC_LAST_EN
      checks++;
      if (l !== 1'b0) begin failures++; $display("[TB] FAIL reset_last dut%0d: got %b expected 0", d, l); end
`endif
    end
  endtask

  // Offer one vector in IDLE, then drain it with randomised out_ready.
  task automatic runVector(input bit use8, input logic [7:0] vec, input int readyPct);
    int         q[$];
    int         n;
    int         guard;
    bit         rdy;
    logic [2:0] idx;
    logic       v, r, l;
    n = use8 ? 8 : 4;
    for (int i = 0; i < n; i++) if (vec[i]) q.push_back(i);
    sample(use8, idx, v, r, l);
    checks++;
    if (r !== 1'b1) begin failures++; $display("[TB] FAIL accept_ready vec=%h: got %b expected 1", vec, r); end
    drive(use8, 1'b1, vec, 1'b0);
    @(negedge clk);
    drive(use8, 1'b0, 8'h00, 1'b0);
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      sample(use8, idx, v, r, l);
      checks++;
      if (v !== 1'b1) begin failures++; $display("[TB] FAIL emit_valid vec=%h: got %b expected 1", vec, v); end
      checks++;
      if (idx !== 3'(q[0])) begin failures++; $display("[TB] FAIL emit_idx vec=%h: got %0d expected %0d", vec, idx, q[0]); end
      checks++;
      if (r !== 1'b0) begin failures++; $display("[TB] FAIL emit_in_ready vec=%h: got %b expected 0", vec, r); end
`ifdef ENC_LAST_EN
      checks++;
      if (l !== (q.size() == 1)) begin failures++; $display("[TB] FAIL emit_last vec=%h: got %b expected %b", vec, l, q.size() == 1); end
`endif
      rdy = ($urandom_range(99) < readyPct);
      drive(use8, 1'b0, 8'h00, rdy);
      @(negedge clk);
      if (rdy) void'(q.pop_front());
      guard++;
    end
    checks++;
    if (guard >= 200) begin failures++; $display("[TB] FAIL drain_timeout vec=%h: got %0d cycles expected under 200", vec, guard); end
    drive(use8, 1'b0, 8'h00, 1'b0);
    sample(use8, idx, v, r, l);
    checks++;
    if (v !== 1'b0) begin failures++; $display("[TB] FAIL done_valid vec=%h: got %b expected 0", vec, v); end
    checks++;
    if (r !== 1'b1) begin failures++; $display("[TB] FAIL done_ready vec=%h: got %b expected 1", vec, r); end
  endtask

  task automatic test_directed();
    runVector(0, 8'b1010, 100);
    runVector(0, 8'b0000, 100);
    runVector(0, 8'b1111, 100);
    runVector(1, 8'hFF, 100);
    runVector(1, 8'h80, 100);
  endtask

  task automatic test_stall();
    logic [2:0] idx;
    logic v, r, l;
    drive(0, 1'b1, 8'b0001, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      sample(0, idx, v, r, l);
      checks++;
      if (v !== 1'b1 || idx !== 3'd0) begin
        failures++; $display("[TB] FAIL stall_hold cyc%0d: got v=%b idx=%0d expected v=1 idx=0", c, v, idx);
      end
`ifdef ENC_LAST_EN
      checks++;
      if (l !== 1'b1) begin failures++; $display("[TB] FAIL stall_last cyc%0d: got %b expected 1", c, l); end
`endif
      @(negedge clk);
    end
    drive(0, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    sample(0, idx, v, r, l);
    checks++;
    if (v !== 1'b0 || r !== 1'b1) begin
      failures++; $display("[TB] FAIL stall_release: got v=%b rdy=%b expected v=0 rdy=1", v, r);
    end
  endtask

  task automatic test_reset_mid_emit();
    logic [2:0] idx;
    logic v, r, l;
    drive(0, 1'b1, 8'b1111, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    sample(0, idx, v, r, l);
    checks++;
    if (v !== 1'b1 || idx !== 3'd2) begin
      failures++; $display("[TB] FAIL pre_reset_idx: got v=%b idx=%0d expected v=1 idx=2", v, idx);
    end
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sample(0, idx, v, r, l);
    checks++;
    if (v !== 1'b0 || r !== 1'b1) begin
      failures++; $display("[TB] FAIL mid_reset: got v=%b rdy=%b expected v=0 rdy=1", v, r);
    end
    runVector(0, 8'b0100, 100);
  endtask

  task automatic test_held_valid();
    logic [2:0] idx;
    logic v, r, l;
    logic [2:0] expIdx [3] = '{3'd0, 3'd1, 3'd3};
    drive(0, 1'b1, 8'b0011, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 8'b1000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      sample(0, idx, v, r, l);
      checks++;
      if (v !== 1'b1 || idx !== expIdx[k] || r !== 1'b0) begin
        failures++; $display("[TB] FAIL held_emit%0d: got v=%b idx=%0d rdy=%b expected v=1 idx=%0d rdy=0", k, v, idx, r, expIdx[k]);
      end
      @(negedge clk);
    end
    sample(0, idx, v, r, l);
    checks++;
    if (v !== 1'b0 || r !== 1'b1) begin
      failures++; $display("[TB] FAIL held_idle_gap: got v=%b rdy=%b expected v=0 rdy=1", v, r);
    end
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b1);
    sample(0, idx, v, r, l);
    checks++;
    if (v !== 1'b1 || idx !== expIdx[2]) begin
      failures++; $display("[TB] FAIL held_second: got v=%b idx=%0d expected v=1 idx=3", v, idx);
    end
`ifdef ENC_LAST_EN
    checks++;
    if (l !== 1'b1) begin failures++; $display("[TB] FAIL held_second_last: got %b expected 1", l); end
`endif
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 1'b0);
    sample(0, idx, v, r, l);
    checks++;
    if (v !== 1'b0 || r !== 1'b1) begin
      failures++; $display("[TB] FAIL held_done: got v=%b rdy=%b expected v=0 rdy=1", v, r);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) runVector(0, 8'($urandom_range(15)), 60);
    for (int t = 0; t < 12; t++) runVector(1, 8'($urandom_range(255)), 70);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_emit();
    test_held_valid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
